// File: rtl/cache_lru_replacer.sv
// 4-way age-based LRU replacement tracker.
// Per-set ages and valid bits, registered victim selection.
module cache_lru_replacer #(
  parameter int SETS  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic             access,
  input  logic [1:0]       hit_way,
  input  logic             replace,
  input  logic             flush,
  output logic [1:0]       victim_way,
  output logic             victim_valid,
  output logic             set_full
);

  typedef logic [3:0][1:0] ages_t;

  localparam ages_t INIT_AGES = {2'd3, 2'd2, 2'd1, 2'd0};

  function automatic ages_t touch(
    input ages_t      a,
    input logic [1:0] w
  );
    ages_t r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[i] < a[w]) r[i] = a[i] + 2'd1;
    end
    r[w] = 2'd0;
    return r;
  endfunction

  logic [SETS-1:0][3:0][1:0] age_q, age_d;
  logic [SETS-1:0][3:0]      vld_q, vld_d;
  logic [1:0]                vw_q, vw_d;
  logic                      vv_q, vv_d;
  logic                      sf_q, sf_d;
  logic                      rdy_q;

  ages_t      cur_age;
  logic [3:0] cur_vld;
  logic [1:0] vic;
  logic       found;
  logic       fl_go, rep_go, acc_go;

  assign cur_age = age_q[index];
  assign cur_vld = vld_q[index];

  // Lowest invalid way wins; otherwise the way aged 3.
  always_comb begin
    vic   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!cur_vld[i] && !found) begin
        vic   = 2'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_age[i] == 2'd3) vic = 2'(i);
      end
    end
  end

  // First edge after reset release is ignored via rdy_q.
  assign fl_go  = rdy_q & flush;
  assign rep_go = rdy_q & ~flush & replace;
  assign acc_go = rdy_q & ~flush & ~replace & access;

  always_comb begin
    age_d = age_q;
    vld_d = vld_q;
    vw_d  = vw_q;
    vv_d  = 1'b0;
    sf_d  = sf_q;
    unique case (1'b1)
      fl_go: begin
        age_d = {SETS{INIT_AGES}};
        vld_d = '0;
      end
      rep_go: begin
        vw_d              = vic;
        vv_d              = 1'b1;
        sf_d              = &cur_vld;
        vld_d[index][vic] = 1'b1;
        age_d[index]      = touch(cur_age, vic);
      end
      acc_go: begin
        age_d[index] = touch(cur_age, hit_way);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= {SETS{INIT_AGES}};
      vld_q <= '0;
      vw_q  <= 2'd0;
      vv_q  <= 1'b0;
      sf_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      age_q <= age_d;
      vld_q <= vld_d;
      vw_q  <= vw_d;
      vv_q  <= vv_d;
      sf_q  <= sf_d;
      rdy_q <= 1'b1;
    end
  end

  assign victim_way   = vw_q;
  assign victim_valid = vv_q;
  assign set_full     = sf_q;

endmodule

// File: tb/tb_cache_lru_replacer.sv
// Bench for cache_lru_replacer: directed scenarios plus
// random traffic against a recency-list reference model.
module tb_cache_lru_replacer;

  localparam int SETS  = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             reset;
  logic [IDX_W-1:0] index;
  logic             access;
  logic [1:0]       hit_way;
  logic             replace;
  logic             flush;
  logic [1:0]       victim_way;
  logic             victim_valid;
  logic             set_full;

  cache_lru_replacer #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .index        (index),
    .access       (access),
    .hit_way      (hit_way),
    .replace      (replace),
    .flush        (flush),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .set_full     (set_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: ord[s][0] is the MRU way, ord[s][3] the LRU way.
  int ord [SETS][4];
  bit vld [SETS][4];
  bit m_ready;
  bit rel_pend;
  int exp_vw, exp_vv, exp_sf;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int p = 0; p < 4; p++) begin
        ord[s][p] = p;
        vld[s][p] = 1'b0;
      end
  endfunction

  function automatic void m_touch(int s, int w);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction

  function automatic int m_victim(int s);
    for (int w = 0; w < 4; w++) if (!vld[s][w]) return w;
    return ord[s][3];
  endfunction

  task automatic cyc(int idx, bit acc, int hw, bit rep, bit fl);
    int v;
    @(negedge clk);
    if (rel_pend) begin
      reset    = 1'b1;
      rel_pend = 1'b0;
    end
    index   = IDX_W'(idx);
    access  = acc;
    hit_way = 2'(hw);
    replace = rep;
    flush   = fl;
    if (!m_ready) begin
      exp_vv  = 0;
      m_ready = 1'b1;
    end else if (fl) begin
      m_reset();
      exp_vv = 0;
    end else if (rep) begin
      v      = m_victim(idx);
      exp_sf = (vld[idx][0] && vld[idx][1] && vld[idx][2] && vld[idx][3]) ? 1 : 0;
      vld[idx][v] = 1'b1;
      m_touch(idx, v);
      exp_vw = v;
      exp_vv = 1;
    end else begin
      if (acc) m_touch(idx, hw);
      exp_vv = 0;
    end
    @(posedge clk);
    #1;
    chk("victim_valid", 32'(victim_valid), 32'(exp_vv));
    chk("victim_way", 32'(victim_way), 32'(exp_vw));
    chk("set_full", 32'(set_full), 32'(exp_sf));
  endtask

  task automatic rep_chk(string tag, int idx, int ev, int esf);
    cyc(idx, 0, 0, 1, 0);
    chk(tag, 32'(victim_way), 32'(ev));
    chk({tag, "_full"}, 32'(set_full), 32'(esf));
  endtask

  task automatic fill(int idx);
    for (int w = 0; w < 4; w++) cyc(idx, 0, 0, 1, 0);
  endtask

  task automatic model_hw_reset();
    m_reset();
    m_ready = 1'b0;
    exp_vv  = 0;
    exp_vw  = 0;
    exp_sf  = 0;
  endtask

  initial begin
    index    = '0;
    access   = 1'b0;
    hit_way  = 2'd0;
    replace  = 1'b0;
    flush    = 1'b0;
    rel_pend = 1'b0;
    reset    = 1'b1;
    model_hw_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_vv", 32'(victim_valid), 32'd0);
    chk("rst_vw", 32'(victim_way), 32'd0);
    chk("rst_sf", 32'(set_full), 32'd0);
    repeat (2) @(posedge clk);

    // Replace in the release cycle is dropped.
    rel_pend = 1'b1;
    cyc(2, 0, 0, 1, 0);
    chk("release_ignored", 32'(victim_valid), 32'd0);

    rep_chk("s2_r0", 2, 0, 0);
    rep_chk("s2_r1", 2, 1, 0);
    rep_chk("s2_r2", 2, 2, 0);
    rep_chk("s2_r3", 2, 3, 0);
    rep_chk("s2_r4", 2, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("strobe_one_cycle", 32'(victim_valid), 32'd0);
    chk("vw_hold", 32'(victim_way), 32'd0);

    fill(0);
    cyc(0, 1, 0, 0, 0);
    rep_chk("s0_after_hit0", 0, 1, 1);

    fill(1);
    for (int w = 3; w >= 0; w--) cyc(1, 1, w, 0, 0);
    rep_chk("s1_lru3", 1, 3, 1);
    rep_chk("s5_untouched", 5, 0, 0);

    fill(3);
    cyc(3, 1, 2, 1, 0);
    chk("rep_over_acc", 32'(victim_way), 32'd0);
    rep_chk("way2_not_mru", 3, 1, 1);

    fill(4);
    cyc(0, 0, 0, 0, 1);
    chk("flush_vv", 32'(victim_valid), 32'd0);
    rep_chk("post_flush", 4, 0, 0);
    cyc(4, 1, 1, 1, 1);
    chk("flush_over_rep", 32'(victim_valid), 32'd0);

    rep_chk("s6_first", 6, 0, 0);
    rep_chk("s6_second", 6, 1, 0);
    #2 reset = 1'b0;
    model_hw_reset();
    #1;
    chk("async_vv", 32'(victim_valid), 32'd0);
    chk("async_vw", 32'(victim_way), 32'd0);
    rel_pend = 1'b1;
    cyc(6, 1, 3, 0, 0);
    rep_chk("s6_after_rst", 6, 0, 0);

    for (int n = 0; n < 600; n++) begin
      int r;
      bit a, rp, f;
      r  = $urandom_range(0, 99);
      f  = (r < 3);
      rp = (r >= 3 && r < 50) || (r >= 90);
      a  = (r >= 50) || ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, SETS-1), a, $urandom_range(0, 3), rp, f);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
